// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the shared iterative mult/div engines and owns the architectural HI/LO registers.
// Defining MULDIV_ABORT_EN lets abort_i cancel a running op with a one-cycle *_stop pulse.
module muldiv_ctrl #(
    parameter int W        = 32,
    parameter int DIV_LAT  = 34,
    parameter int MULT_LAT = 33
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         wr_hi_i,
    input  logic         wr_lo_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         abort_i,
    output logic [W-1:0] eng_a_o,
    output logic [W-1:0] eng_b_o,
    output logic         div_init_o,
    output logic         div_stop_o,
    input  logic [W-1:0] div_hi_i,
    input  logic [W-1:0] div_lo_i,
    output logic         mult_init_o,
    output logic         mult_stop_o,
    input  logic [W-1:0] mult_hi_i,
    input  logic [W-1:0] mult_lo_i,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         divzero_exc_o
);
    localparam int MAX_LAT = DIV_LAT > MULT_LAT ? DIV_LAT : MULT_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, WB, EXC} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          op_q;
    logic [W-1:0]  eng_a_q, eng_b_q, hi_q, lo_q;
    logic          div_init_q, mult_init_q, busy_q, done_q, exc_q;
`ifdef MULDIV_ABORT_EN
    logic          div_stop_q, mult_stop_q;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= 1'b0;
            eng_a_q     <= '0;
            eng_b_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            div_init_q  <= 1'b0;
            mult_init_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            exc_q       <= 1'b0;
`ifdef MULDIV_ABORT_EN
            div_stop_q  <= 1'b0;
            mult_stop_q <= 1'b0;
`endif
        end else begin
            div_init_q  <= 1'b0;
            mult_init_q <= 1'b0;
            done_q      <= 1'b0;
            exc_q       <= 1'b0;
`ifdef MULDIV_ABORT_EN
            div_stop_q  <= 1'b0;
            mult_stop_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (wr_hi_i) hi_q <= wr_data_i;
                    if (wr_lo_i) lo_q <= wr_data_i;
                    if (start_i) begin
                        eng_a_q <= a_i;
                        eng_b_q <= b_i;
                        op_q    <= op_i;
                        busy_q  <= 1'b1;
                        // divide by zero never starts the divider
                        if (op_i && b_i == '0) begin
                            state_q <= EXC;
                            exc_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= RUN;
                            cnt_q       <= op_i ? CW'(DIV_LAT) : CW'(MULT_LAT);
                            div_init_q  <= op_i;
                            mult_init_q <= !op_i;
                        end
                    end
                end
                RUN: begin
`ifdef MULDIV_ABORT_EN
                    if (abort_i) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        cnt_q       <= '0;
                        div_stop_q  <= op_q;
                        mult_stop_q <= !op_q;
                    end else
`endif
                    if (cnt_q == '0) begin
                        hi_q    <= op_q ? div_hi_i : mult_hi_i;
                        lo_q    <= op_q ? div_lo_i : mult_lo_i;
                        done_q  <= 1'b1;
                        state_q <= WB;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                WB, EXC: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MULDIV_ABORT_EN
    assign div_stop_o  = div_stop_q;
    assign mult_stop_o = mult_stop_q;
`else
    logic unused_abort;
    assign unused_abort = abort_i;
    assign div_stop_o   = 1'b0;
    assign mult_stop_o  = 1'b0;
`endif

    assign eng_a_o       = eng_a_q;
    assign eng_b_o       = eng_b_q;
    assign div_init_o    = div_init_q;
    assign mult_init_o   = mult_init_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign divzero_exc_o = exc_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed bench with behavioural engines and a result scoreboard for muldiv_ctrl.
module tb_muldiv_ctrl;
    localparam int W        = 32;
    localparam int DIV_LAT  = 34;
    localparam int MULT_LAT = 33;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         start_i = 1'b0, op_i = 1'b0;
    logic [W-1:0] a_i = '0, b_i = '0, wr_data_i = '0;
    logic         wr_hi_i = 1'b0, wr_lo_i = 1'b0, abort_i = 1'b0;
    logic [W-1:0] eng_a_o, eng_b_o, div_hi_i, div_lo_i, mult_hi_i, mult_lo_i, hi_o, lo_o;
    logic         div_init_o, div_stop_o, mult_init_o, mult_stop_o, busy_o, done_o, divzero_exc_o;

    muldiv_ctrl #(.W(W), .DIV_LAT(DIV_LAT), .MULT_LAT(MULT_LAT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .wr_hi_i(wr_hi_i), .wr_lo_i(wr_lo_i), .wr_data_i(wr_data_i), .abort_i(abort_i),
        .eng_a_o(eng_a_o), .eng_b_o(eng_b_o), .div_init_o(div_init_o), .div_stop_o(div_stop_o),
        .div_hi_i(div_hi_i), .div_lo_i(div_lo_i), .mult_init_o(mult_init_o), .mult_stop_o(mult_stop_o),
        .mult_hi_i(mult_hi_i), .mult_lo_i(mult_lo_i), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o),
        .done_o(done_o), .divzero_exc_o(divzero_exc_o)
    );

    always #5 clk_i = ~clk_i;

    // engines drive junk except in the single cycle their result is valid
    int           dage = 0, mage = 0, mult_inits = 0, div_inits = 0;
    logic         dact = 1'b0, mact = 1'b0;
    logic [W-1:0] dq, dr;
    logic [63:0]  mp;
    always @(posedge clk_i) begin
        if (div_init_o) begin dact <= 1'b1; dage <= 1; div_inits <= div_inits + 1; end
        else if (dact && dage < 100) dage <= dage + 1;
        if (mult_init_o) begin mact <= 1'b1; mage <= 1; mult_inits <= mult_inits + 1; end
        else if (mact && mage < 100) mage <= mage + 1;
    end
    always_comb begin
        dq = (eng_b_o == '0) ? '0 : eng_a_o / eng_b_o;
        dr = (eng_b_o == '0) ? '0 : eng_a_o % eng_b_o;
        mp = {32'b0, eng_a_o} * {32'b0, eng_b_o};
        div_hi_i  = (dact && dage == DIV_LAT) ? dr : ~dr ^ 32'h5A5A_0000;
        div_lo_i  = (dact && dage == DIV_LAT) ? dq : ~dq ^ 32'h0000_A5A5;
        mult_hi_i = (mact && mage == MULT_LAT) ? mp[63:32] : ~mp[63:32] ^ 32'h1234_0000;
        mult_lo_i = (mact && mage == MULT_LAT) ? mp[31:0] : ~mp[31:0] ^ 32'h0000_4321;
    end

    typedef struct { logic exc; logic [W-1:0] hi; logic [W-1:0] lo; } exp_t;
    exp_t         sb[$];
    logic [W-1:0] m_hi = '0, m_lo = '0;
    int           checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (rst_i === 1'b1 && done_o === 1'b1) begin
            exp_t e;
            chk("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("res_hi", 64'(hi_o), 64'(e.hi));
                chk("res_lo", 64'(lo_o), 64'(e.lo));
                chk("res_exc", 64'(divzero_exc_o), 64'(e.exc));
            end
        end
    end

    task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
        exp_t         e;
        int           lat, mi0;
        logic [W-1:0] h0, l0;
        logic [63:0]  p;
        lat = op ? DIV_LAT : MULT_LAT;
        p   = {32'b0, a} * {32'b0, b};
        if (op && b == '0) e = '{1'b1, m_hi, m_lo};
        else if (op)       e = '{1'b0, a % b, a / b};
        else               e = '{1'b0, p[63:32], p[31:0]};
        sb.push_back(e);
        h0 = m_hi; l0 = m_lo; m_hi = e.hi; m_lo = e.lo; mi0 = mult_inits;
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        tick;
        start_i = 1'b0; wr_hi_i = 1'b0; wr_lo_i = 1'b0;
        chk("c1_busy", 64'(busy_o), 64'd1);
        chk("c1_hi", 64'(hi_o), 64'(h0));
        chk("c1_lo", 64'(lo_o), 64'(l0));
        chk("c1_eng_a", 64'(eng_a_o), 64'(a));
        chk("c1_eng_b", 64'(eng_b_o), 64'(b));
        chk("c1_stops", 64'({div_stop_o, mult_stop_o}), 64'd0);
        if (e.exc) begin
            chk("exc_pulse", 64'({divzero_exc_o, done_o}), 64'b11);
            chk("exc_no_init", 64'({div_init_o, mult_init_o}), 64'd0);
            tick;
            chk("exc_idle", 64'({busy_o, done_o, divzero_exc_o}), 64'd0);
            return;
        end
        chk("c1_init", 64'({div_init_o, mult_init_o}), 64'({op, !op}));
        chk("c1_done", 64'({done_o, divzero_exc_o}), 64'd0);
        for (int c = 2; c <= lat + 2; c++) begin
            tick;
            chk("run_busy", 64'(busy_o), 64'd1);
            chk("run_done", 64'(done_o), 64'(c == lat + 2));
            chk("run_init", 64'({div_init_o, mult_init_o}), 64'd0);
            if (inject) begin
                if (c == 9) begin start_i = 1'b1; op_i = 1'b0; a_i = 2; b_i = 2; end
                if (c == 10) start_i = 1'b0;
                if (c == 15) begin wr_hi_i = 1'b1; wr_data_i = 32'hDEAD; end
                if (c == 16) wr_hi_i = 1'b0;
                if (c == 17) chk("run_wr_ignored", 64'(hi_o), 64'(h0));
            end
        end
        tick;
        chk("post_busy", 64'({busy_o, done_o}), 64'd0);
        if (inject) chk("ignored_start", 64'(mult_inits), 64'(mi0));
    endtask

    initial begin
        tick; tick;
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("rst_eng", {eng_a_o, eng_b_o}, 64'd0);
        chk("rst_strobes", 64'({busy_o, done_o, divzero_exc_o, div_init_o, mult_init_o, div_stop_o, mult_stop_o}), 64'd0);
        rst_i = 1'b1;
        tick;
        run_op(1'b1, 7, 2, 1'b1);
        chk("div_7_2", {hi_o, lo_o}, {32'd1, 32'd3});
        wr_hi_i = 1'b1; wr_data_i = 32'hDEAD; m_hi = 32'hDEAD;
        tick;
        wr_hi_i = 1'b0;
        chk("wr_hi_idle", {hi_o, lo_o}, {32'hDEAD, 32'd3});
        run_op(1'b0, 3, 5, 1'b0);
        chk("mult_3_5", {hi_o, lo_o}, {32'd0, 32'd15});
        run_op(1'b1, 9, 0, 1'b0);
        chk("divzero_hold", {hi_o, lo_o}, {32'd0, 32'd15});
        run_op(1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
        wr_hi_i = 1'b1; wr_lo_i = 1'b1; wr_data_i = 32'hCAFE_F00D;
        m_hi = 32'hCAFE_F00D; m_lo = 32'hCAFE_F00D;
        run_op(1'b1, 32'hFFFF_FFF0, 7, 1'b0);
        chk("div_big", {hi_o, lo_o}, {32'hFFFF_FFF0 % 32'd7, 32'hFFFF_FFF0 / 32'd7});
        op_i = 1'b1; a_i = 100; b_i = 3; start_i = 1'b1;
        tick;
        start_i = 1'b0;
        chk("rstmid_init", 64'(div_init_o), 64'd1);
        for (int i = 0; i < 19; i++) tick;
        rst_i = 1'b0;
        tick;
        rst_i = 1'b1;
        m_hi = '0; m_lo = '0;
        chk("rstmid_state", 64'({busy_o, done_o, div_stop_o, mult_stop_o}), 64'd0);
        chk("rstmid_hilo", {hi_o, lo_o}, 64'd0);
        for (int i = 0; i < 40; i++) tick;
        chk("rstmid_no_done", 64'(busy_o), 64'd0);
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);
        chk("mult_carry", {hi_o, lo_o}, {32'd1, 32'd0});
        tick;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
